// File: rtl/param_loader_pkg.sv
// Shared fixed-point constants and FSM state type for the per-layer parameter loader.
// FP_N is the parameter word width; END_MARK terminates every node frame.
package param_loader_pkg;

  localparam int FP_N = 16;
  localparam logic [FP_N-1:0] END_MARK = 16'h7FFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/param_loader.sv
// Streams sl*(sx+2) words from a synchronous parameter ROM onto the layer bus with a one-hot node we.
// Optional end-marker check of every frame is enabled by defining PARAM_LOADER_END_CHECK_EN.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int sx   = 99,
  parameter int sl   = 99,
  parameter int BASE = 0,
  parameter int AW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  input  logic [FP_N-1:0] mem_data,
  output logic [FP_N-1:0] bus,
  output logic            bus_oe,
  output logic [sl-1:0]   we
);

  localparam int N   = FP_N;
  localparam int W   = sx + 2;
  localparam int WCW = $clog2(W);
  localparam int NCW = (sl > 1) ? $clog2(sl) : 1;

  localparam logic [AW-1:0]  BASE_ADDR = AW'(BASE);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(BASE + sl * W - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(W - 1);

  // Issue stage: address generator and control
  state_e         state_q;
  logic [AW-1:0]  mem_addr_q;
  logic           mem_rd_q;
  logic [WCW-1:0] word_cnt_q;
  logic [NCW-1:0] node_cnt_q;
  logic           busy_q;
  logic           done_q;

  // Read stage: tags travelling alongside the ROM access
  logic           rd_v_q;
  logic [NCW-1:0] rd_node_q;
  logic           rd_final_q;

  // Output stage
  logic [N-1:0]   bus_d,  bus_q;
  logic [sl-1:0]  we_d,   we_q;
  logic           bus_oe_q;
  logic           last_out_q;

  logic           start_accept;

  assign start_accept = (state_q == S_IDLE) && start;

  // NOTE: every register below is updated with <= so all stages sample the pre-edge values;
  // blocking assignments here would let the counters race ahead of the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= BASE_ADDR;
      mem_rd_q   <= 1'b0;
      word_cnt_q <= '0;
      node_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= BASE_ADDR;
            word_cnt_q <= '0;
            node_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (mem_addr_q == LAST_ADDR) begin
            state_q  <= S_DRAIN;
            mem_rd_q <= 1'b0;
          end else begin
            mem_addr_q <= mem_addr_q + 1'b1;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q <= '0;
              node_cnt_q <= node_cnt_q + 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_out_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v_q     <= 1'b0;
      rd_node_q  <= '0;
      rd_final_q <= 1'b0;
    end else begin
      rd_v_q     <= mem_rd_q;
      rd_node_q  <= node_cnt_q;
      rd_final_q <= mem_rd_q && (mem_addr_q == LAST_ADDR);
    end
  end

  // NOTE: defaults first so no path leaves bus_d/we_d unassigned and infers a latch.
  always_comb begin
    bus_d = '0;
    we_d  = '0;
    if (rd_v_q) begin
      bus_d = mem_data;
      for (int k = 0; k < sl; k++) begin
        if (rd_node_q == NCW'(k)) begin
          we_d[sl-1-k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q      <= '0;
      we_q       <= '0;
      bus_oe_q   <= 1'b0;
      last_out_q <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      we_q       <= we_d;
      bus_oe_q   <= rd_v_q;
      last_out_q <= rd_final_q;
    end
  end

`ifdef PARAM_LOADER_END_CHECK_EN
  logic rd_end_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_end_q <= 1'b0;
    end else begin
      rd_end_q <= mem_rd_q && (word_cnt_q == LAST_WORD);
    end
  end

  // Flag is registered at the same edge the end word reaches the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (start_accept) begin
      err_q <= 1'b0;
    end else if (rd_v_q && rd_end_q && (mem_data != END_MARK)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign bus      = bus_q;
  assign bus_oe   = bus_oe_q;
  assign we       = we_q;

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader with sx=2, sl=3, BASE=0; ROM word a = a+1, frame ends = END_MARK.
// Edge numbering: edge 0 is the rising edge that samples the accepted start; outputs are read 1 ns after each edge.
module tb_param_loader;
  import param_loader_pkg::*;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     mem_addr;
  logic            mem_rd;
  logic [FP_N-1:0] mem_data;
  logic [FP_N-1:0] bus;
  logic            bus_oe;
  logic [2:0]      we;

  logic [15:0] rom [16];

  int n_checks = 0;
  int n_pass   = 0;

  param_loader #(
    .sx  (2),
    .sl  (3),
    .BASE(0),
    .AW  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_data(mem_data),
    .bus     (bus),
    .bus_oe  (bus_oe),
    .we      (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_rd(logic [15:0] a);
    return (a < 16'd16) ? rom[a[3:0]] : 16'h0000;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_rd) mem_data <= rom_rd(mem_addr);
  end

  // Hand model of the default ROM image: three frames of {1,2,3,END}-style words.
  function automatic logic [15:0] exp_word(int a);
    return (a % 4 == 3) ? END_MARK : 16'(a + 1);
  endfunction

  function automatic logic [2:0] exp_we_of(int node);
    logic [2:0] top;
    top = 3'b100;
    return top >> node;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({busy, done, err, mem_rd, bus_oe, bus, we, mem_addr} !== '0) begin
        $display("FAIL reset_idle cyc %0d: busy=%b done=%b err=%b rd=%b oe=%b bus=%h we=%b addr=%0d, want all 0",
                 i, busy, done, err, mem_rd, bus_oe, bus, we, mem_addr);
      end else n_pass++;
    end
  endtask

  task automatic test_single_load();
    logic [2:0]  ewe;
    logic [15:0] ebus;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({mem_addr, mem_rd, busy} !== {16'd0, 1'b1, 1'b1}) begin
      $display("FAIL load_start: addr=%0d rd=%b busy=%b, want 0 1 1", mem_addr, mem_rd, busy);
    end else n_pass++;
    for (int e = 1; e <= 16; e++) begin
      tick();
      ewe  = (e >= 2 && e <= 13) ? exp_we_of((e - 2) / 4) : 3'b000;
      ebus = (e >= 2 && e <= 13) ? exp_word(e - 2) : 16'h0000;
      n_checks++;
      if ({we, bus_oe, bus} !== {ewe, (ewe != 3'b000), ebus}) begin
        $display("FAIL load_data edge %0d: we=%b oe=%b bus=%h, want we=%b oe=%b bus=%h",
                 e, we, bus_oe, bus, ewe, (ewe != 3'b000), ebus);
      end else n_pass++;
      if (e <= 11) begin
        n_checks++;
        if ({mem_addr, mem_rd} !== {16'(e), 1'b1}) begin
          $display("FAIL load_addr edge %0d: addr=%0d rd=%b, want %0d 1", e, mem_addr, mem_rd, e);
        end else n_pass++;
      end
      if (e == 12) begin
        n_checks++;
        if (mem_rd !== 1'b0) begin
          $display("FAIL load_rd_off edge 12: rd=%b, want 0", mem_rd);
        end else n_pass++;
      end
      n_checks++;
      if (done !== (e == 14)) begin
        $display("FAIL load_done edge %0d: done=%b, want %b", e, done, (e == 14));
      end else n_pass++;
      n_checks++;
      if (busy !== (e <= 13)) begin
        $display("FAIL load_busy edge %0d: busy=%b, want %b", e, busy, (e <= 13));
      end else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    int words = 0;
    int dones = 0;
    int done_edge = -1;
    int bad = 0;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 30; e++) begin
      start = (e == 3 || e == 8);
      tick();
      if (we !== 3'b000) begin
        if (we !== exp_we_of(words / 4) || bus !== exp_word(words)) bad++;
        words++;
      end
      if (done === 1'b1) begin
        dones++;
        done_edge = e;
      end
    end
    start = 1'b0;
    n_checks++;
    if (words != 12 || bad != 0) begin
      $display("FAIL ignored_start_words: words=%0d wrong=%0d, want 12 and 0", words, bad);
    end else n_pass++;
    n_checks++;
    if (dones != 1 || done_edge != 14) begin
      $display("FAIL ignored_start_done: pulses=%0d at edge %0d, want 1 at 14", dones, done_edge);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({we, bus_oe, bus, busy, mem_rd} !== '0) begin
      $display("FAIL midload_rst: we=%b oe=%b bus=%h busy=%b rd=%b, want all 0", we, bus_oe, bus, busy, mem_rd);
    end else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || we !== 3'b000) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      $display("FAIL midload_no_done: activity cycles=%0d, want 0", dones);
    end else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (mem_addr !== 16'd0) begin
      $display("FAIL midload_restart_addr: addr=%0d, want 0", mem_addr);
    end else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({we, bus} !== {3'b100, exp_word(0)}) begin
      $display("FAIL midload_restart_word: we=%b bus=%h, want 100 %h", we, bus, exp_word(0));
    end else n_pass++;
    repeat (16) tick();
  endtask

  task automatic test_end_check();
    int dones = 0;
    rom[7] = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (done === 1'b1) dones++;
`ifdef PARAM_LOADER_END_CHECK_EN
      n_checks++;
      if (err !== (e >= 9)) begin
        $display("FAIL endchk_err edge %0d: err=%b, want %b", e, err, (e >= 9));
      end else n_pass++;
`else
      n_checks++;
      if (err !== 1'b0) begin
        $display("FAIL endchk_tied edge %0d: err=%b, want 0", e, err);
      end else n_pass++;
      if (e == 9) begin
        n_checks++;
        if (bus !== 16'h1234) begin
          $display("FAIL endchk_passthru edge 9: bus=%h, want 1234", bus);
        end else n_pass++;
      end
`endif
    end
    n_checks++;
    if (dones != 1) begin
      $display("FAIL endchk_done: pulses=%0d, want 1", dones);
    end else n_pass++;
    rom[7] = END_MARK;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      $display("FAIL endchk_clear: err=%b after new start, want 0", err);
    end else n_pass++;
    repeat (16) tick();
    n_checks++;
    if (err !== 1'b0) begin
      $display("FAIL endchk_clean_load: err=%b after good load, want 0", err);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int we_cycles = 0;
    int dones = 0;
    int first_we2 = -1;
    logic [15:0] first_bus2 = '0;
    logic [2:0]  we_at13 = '0;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 34; e++) begin
      if (e == 21) start = 1'b0;
      tick();
      if (we !== 3'b000) begin
        we_cycles++;
        if (e > 15 && first_we2 < 0) begin
          first_we2  = e;
          first_bus2 = bus;
        end
      end
      if (e == 13) we_at13 = we;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (we_cycles != 24 || dones != 2) begin
      $display("FAIL b2b_counts: we cycles=%0d done pulses=%0d, want 24 and 2", we_cycles, dones);
    end else n_pass++;
    n_checks++;
    if (we_at13 !== 3'b001) begin
      $display("FAIL b2b_last_we1: we at edge 13=%b, want 001", we_at13);
    end else n_pass++;
    n_checks++;
    if (first_we2 != 18 || first_bus2 !== exp_word(0)) begin
      $display("FAIL b2b_second_load: first we at edge %0d bus=%h, want edge 18 bus=%h",
               first_we2, first_bus2, exp_word(0));
    end else n_pass++;
    repeat (4) tick();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 16; a++) rom[a] = exp_word(a);
    test_reset();
    test_single_load();
    repeat (3) tick();
    test_ignored_start();
    repeat (3) tick();
    test_reset_mid_load();
    test_end_check();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
